// File: rtl/fdivsqrt_intpreproc_pkg.sv
// Shared types for the integer-divide preprocessing front end.
package fdivsqrt_intpreproc_pkg;

    // Sequencer states: capture -> sign strip -> normalize -> hand off.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABS   = 2'd1,
        LZC   = 2'd2,
        ISSUE = 2'd3
    } intpreproc_state_t;

    // Number of bits needed to hold a leading-zero count of 0..w.
    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fdivsqrt_intpreproc_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fdivsqrt_intpreproc_lzc
    import fdivsqrt_intpreproc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]              num,
    output logic [lzc_width(WIDTH)-1:0]   zp
);

    localparam int CW = lzc_width(WIDTH);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        zp = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (num[i]) zp = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fdivsqrt_intpreproc.sv
// Integer-divide front end: word adjust, sign strip, normalization and
// iteration-count computation ahead of the digit-recurrence core.
module fdivsqrt_intpreproc
    import fdivsqrt_intpreproc_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DIVb    = 64,
    parameter int DIVBLEN = 7,
    parameter int LOGR    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Flush,
    input  logic                StartValid,
    output logic                StartReady,
    input  logic [XLEN-1:0]     A,
    input  logic [XLEN-1:0]     B,
    input  logic                Signed,
    input  logic                RemOp,
    input  logic                W64,
    output logic                PreValid,
    input  logic                PreReady,
    output logic [DIVb+3:0]     X,
    output logic [DIVb+3:0]     D,
    output logic [DIVBLEN-1:0]  IntNormShift,
    output logic [DIVBLEN-1:0]  CycleCount,
    output logic                As,
    output logic                Bs,
    output logic                BZero,
    output logic                ALTB,
    output logic                Special,
    output logic [XLEN-1:0]     AOut,
    output logic                RemOpOut,
    output logic                W64Out
);

    localparam int LW   = lzc_width(XLEN);
    localparam int PADW = DIVb + 1 - XLEN;

    intpreproc_state_t state, state_next;

    logic [XLEN-1:0]    a_w, b_w;
    logic [XLEN-1:0]    a_p0, b_p0;
    logic               signed_p0;
    logic [XLEN-1:0]    a_abs_p1, b_abs_p1;
    logic [LW-1:0]      ma_lz, mb_lz;
    logic [DIVBLEN-1:0] ma, mb, diff;
    logic               bzero_c, altb_c, special_c;
    logic [DIVBLEN-1:0] ins_c, cyc_c;
    logic [DIVBLEN:0]   cyc_wide;
    logic [XLEN-1:0]    a_norm, b_norm;

    // Two's-complement magnitude; the most negative value maps onto its
    // unsigned magnitude 2^(XLEN-1) because the result is read unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    assign StartReady = (state == IDLE);
    assign PreValid   = (state == ISSUE);

    // Word ops replace each operand by its low half, extended per signedness.
    if (XLEN > 32) begin : g_word
        assign a_w = W64 ? {{(XLEN-32){Signed & A[31]}}, A[31:0]} : A;
        assign b_w = W64 ? {{(XLEN-32){Signed & B[31]}}, B[31:0]} : B;
    end else begin : g_noword
        assign a_w = A;
        assign b_w = B;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; flush overrides everything and blocks new starts.
    always_comb begin
        state_next = state;
        if (Flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (StartValid) state_next = ABS;
                ABS:     state_next = LZC;
                LZC:     state_next = ISSUE;
                ISSUE:   if (PreReady) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---- stage p0: operand capture in IDLE ----
    // Latch word-adjusted operands and op controls on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p0      <= '0;
            b_p0      <= '0;
            signed_p0 <= 1'b0;
            AOut      <= '0;
            RemOpOut  <= 1'b0;
            W64Out    <= 1'b0;
        end else if (state == IDLE && StartValid && !Flush) begin
            a_p0      <= a_w;
            b_p0      <= b_w;
            signed_p0 <= Signed;
            AOut      <= a_w;
            RemOpOut  <= RemOp;
            W64Out    <= W64;
        end
    end

    // ---- stage p1: sign strip in ABS ----
    // Record operand signs and register unsigned magnitudes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            As       <= 1'b0;
            Bs       <= 1'b0;
            a_abs_p1 <= '0;
            b_abs_p1 <= '0;
        end else if (state == ABS) begin
            As       <= signed_p0 & a_p0[XLEN-1];
            Bs       <= signed_p0 & b_p0[XLEN-1];
            a_abs_p1 <= magnitude(a_p0, signed_p0 & a_p0[XLEN-1]);
            b_abs_p1 <= magnitude(b_p0, signed_p0 & b_p0[XLEN-1]);
        end
    end

    // ---- stage p2: normalization in LZC ----
    fdivsqrt_intpreproc_lzc #(.WIDTH(XLEN)) u_lzc_a (
        .num (a_abs_p1),
        .zp  (ma_lz)
    );

    fdivsqrt_intpreproc_lzc #(.WIDTH(XLEN)) u_lzc_b (
        .num (b_abs_p1),
        .zp  (mb_lz)
    );

    // Special-case detection, shift and iteration count from the two counts.
    always_comb begin
        ma        = DIVBLEN'(ma_lz);
        mb        = DIVBLEN'(mb_lz);
        bzero_c   = (b_abs_p1 == '0);
        altb_c    = ~bzero_c & (ma > mb);
        special_c = bzero_c | altb_c;
        diff      = mb - ma;
        a_norm    = a_abs_p1 << ma_lz;
        b_norm    = b_abs_p1 << mb_lz;
        // Quotient has diff+1 integer bits plus one guard step; round up to
        // whole iterations of LOGR bits each.
        cyc_wide  = ({1'b0, diff} + (DIVBLEN+1)'(LOGR + 1)) / (DIVBLEN+1)'(LOGR);
        ins_c     = DIVBLEN'(DIVb) - diff;
        cyc_c     = cyc_wide[DIVBLEN-1:0];
        if (special_c) begin
            ins_c = '0;
            cyc_c = '0;
        end
    end

    // Register the normalized operands and sideband for the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            X            <= '0;
            D            <= '0;
            IntNormShift <= '0;
            CycleCount   <= '0;
            BZero        <= 1'b0;
            ALTB         <= 1'b0;
            Special      <= 1'b0;
        end else if (state == LZC) begin
            X            <= {3'b000, a_norm, {PADW{1'b0}}};
            D            <= {3'b000, b_norm, {PADW{1'b0}}};
            IntNormShift <= ins_c;
            CycleCount   <= cyc_c;
            BZero        <= bzero_c;
            ALTB         <= altb_c;
            Special      <= special_c;
        end
    end

endmodule
